// File: rtl/dmem_multi_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_multi_port_arbiter
//
// Funnels NUM_LOAD_PORTS load channels and one store channel onto a single
// data-memory port, issuing at most one request per cycle. Load ports are
// served round-robin; the class that loses the load/store preference is aged
// so it cannot starve. Issued loads are remembered in an in-order tag FIFO so
// each memory response is steered back to the port that asked for it.
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   load_request_valid/ready     per-port load handshake (ready is one-hot)
//   load_request_address         packed per-port addresses, port i at [i*XLEN +: XLEN]
//   load_response_valid          one-hot owner of this cycle's memory response
//   load_response_address/value  pass-through of memory_address_in / memory_data_in
//   store_request_*              store handshake, address, data, byte enables
//   memory_read/write            request issued to memory this cycle
//   memory_address_out           granted load address, else store address
//   memory_data_out/byte_en      store data / byte enables
//   memory_data_in/address_in    load response payload
//   memory_valid                 load response strobe (always accepted)
//   memory_ready                 memory can take a request this cycle
//   outstanding_count            loads in flight
//   response_error               sticky: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module dmem_multi_port_arbiter #(
    parameter int XLEN              = 64,
    parameter int NUM_LOAD_PORTS    = 2,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int LOADS_OVER_STORES = 0,
    parameter int MAX_WAIT          = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_LOAD_PORTS-1:0]            load_request_valid,
    output logic [NUM_LOAD_PORTS-1:0]            load_request_ready,
    input  logic [NUM_LOAD_PORTS*XLEN-1:0]       load_request_address,
    output logic [NUM_LOAD_PORTS-1:0]            load_response_valid,
    output logic [XLEN-1:0]                      load_response_address,
    output logic [XLEN-1:0]                      load_response_value,
    input  logic                                 store_request_valid,
    output logic                                 store_request_ready,
    input  logic [XLEN-1:0]                      store_request_address,
    input  logic [XLEN-1:0]                      store_request_value,
    input  logic [XLEN/8-1:0]                    store_request_byte_en,
    output logic                                 memory_read,
    output logic                                 memory_write,
    output logic [XLEN/8-1:0]                    memory_byte_en,
    output logic [XLEN-1:0]                      memory_address_out,
    output logic [XLEN-1:0]                      memory_data_out,
    input  logic [XLEN-1:0]                      memory_data_in,
    input  logic [XLEN-1:0]                      memory_address_in,
    input  logic                                 memory_valid,
    input  logic                                 memory_ready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count,
    output logic                                 response_error
);

    localparam int PW   = (NUM_LOAD_PORTS > 1) ? $clog2(NUM_LOAD_PORTS) : 1;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW   = $clog2(MAX_OUTSTANDING);
    localparam int AGEW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AGEW-1:0] age_q, age_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [PW-1:0]   tag_mem_q [MAX_OUTSTANDING];

    logic [XLEN-1:0] load_addr [NUM_LOAD_PORTS];
    logic [PW-1:0]   cand_idx;
    logic            cand_found;
    logic            load_elig, store_elig, age_at_max, prefer_load;
    logic            issue_en, grant_load, grant_store;
    logic            fifo_empty, pop, resp_fire;
    logic [PW-1:0]   head_tag;

    // Unpack addresses and build the one-hot ready / response vectors.
    generate
        for (genvar gi = 0; gi < NUM_LOAD_PORTS; gi++) begin : g_port
            assign load_addr[gi]           = load_request_address[gi*XLEN +: XLEN];
            assign load_request_ready[gi]  = grant_load && (cand_idx == PW'(gi));
            assign load_response_valid[gi] = resp_fire && (head_tag == PW'(gi));
        end
    endgenerate

    // First valid port at or after rr_ptr, wrapping. Scanned from the far end
    // so the nearest port is the last (winning) assignment.
    always_comb begin
        logic [PW:0] sum;
        sum        = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int k = NUM_LOAD_PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_LOAD_PORTS)) begin
                sum = sum - (PW+1)'(NUM_LOAD_PORTS);
            end
            if (load_request_valid[sum[PW-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = sum[PW-1:0];
            end
        end
    end

    // Reset is folded in so nothing is granted while it is asserted.
    assign issue_en    = memory_ready && reset;
    assign load_elig   = cand_found && (count_q < CW'(MAX_OUTSTANDING));
    assign store_elig  = store_request_valid;
    assign age_at_max  = (MAX_WAIT != 0) && (age_q == AGEW'(MAX_WAIT));
    // Aged-out non-preferred class flips the preference for one grant.
    assign prefer_load = (LOADS_OVER_STORES != 0) ? !age_at_max : age_at_max;
    assign grant_load  = issue_en && load_elig && (!store_elig || prefer_load);
    assign grant_store = issue_en && store_elig && !(load_elig && prefer_load);

    assign memory_read         = grant_load;
    assign memory_write        = grant_store;
    assign store_request_ready = grant_store;
    assign memory_address_out  = grant_load ? load_addr[cand_idx] : store_request_address;
    assign memory_data_out     = store_request_value;
    assign memory_byte_en      = store_request_byte_en;

    assign fifo_empty            = (count_q == '0);
    assign pop                   = memory_valid && !fifo_empty;
    assign resp_fire             = pop && reset;
    assign head_tag              = tag_mem_q[rd_ptr_q];
    assign load_response_address = memory_address_in;
    assign load_response_value   = memory_data_in;
    assign outstanding_count     = count_q;
    assign response_error        = err_q;

    always_comb begin
        logic np_valid, np_grant;
        np_valid = (LOADS_OVER_STORES != 0) ? store_request_valid : (|load_request_valid);
        np_grant = (LOADS_OVER_STORES != 0) ? grant_store : grant_load;

        rr_ptr_d = rr_ptr_q;
        if (grant_load) begin
            rr_ptr_d = (cand_idx == PW'(NUM_LOAD_PORTS - 1)) ? '0 : cand_idx + PW'(1);
        end

        age_d = age_q;
        if (np_grant) begin
            age_d = '0;
        end else if (np_valid && memory_ready && (age_q != AGEW'(MAX_WAIT))) begin
            age_d = age_q + AGEW'(1);
        end

        wr_ptr_d = grant_load ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({grant_load, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        err_d = err_q || (memory_valid && fifo_empty);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            age_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            age_q    <= age_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Tag storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clock) begin
        if (grant_load) begin
            tag_mem_q[wr_ptr_q] <= cand_idx;
        end
    end

endmodule

// File: tb/tb_dmem_multi_port_arbiter.sv
module tb_dmem_multi_port_arbiter;

    // Three instances: u0 stores preferred / MAX_WAIT=8, u1 stores preferred /
    // aging off, u2 loads preferred / MAX_WAIT=3.
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  lrv [3];
    logic [1:0]  lrr [3];
    logic [1:0]  rspv [3];
    logic [127:0] lra [3];
    logic [63:0] rspa [3], rspd [3], sra [3], srd [3];
    logic [63:0] mao [3], mdo [3], mdi [3], mai [3];
    logic        srv [3], srr [3], mrd [3], mwr [3], mv [3], mrdy [3], rerr [3];
    logic [7:0]  sbe [3], mbe [3];
    logic [2:0]  oc [3];

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    dmem_multi_port_arbiter #(.LOADS_OVER_STORES(0), .MAX_WAIT(8)) u0 (
        .clock(clk), .reset(rst_n),
        .load_request_valid(lrv[0]), .load_request_ready(lrr[0]), .load_request_address(lra[0]),
        .load_response_valid(rspv[0]), .load_response_address(rspa[0]), .load_response_value(rspd[0]),
        .store_request_valid(srv[0]), .store_request_ready(srr[0]), .store_request_address(sra[0]),
        .store_request_value(srd[0]), .store_request_byte_en(sbe[0]),
        .memory_read(mrd[0]), .memory_write(mwr[0]), .memory_byte_en(mbe[0]),
        .memory_address_out(mao[0]), .memory_data_out(mdo[0]), .memory_data_in(mdi[0]),
        .memory_address_in(mai[0]), .memory_valid(mv[0]), .memory_ready(mrdy[0]),
        .outstanding_count(oc[0]), .response_error(rerr[0]));

    dmem_multi_port_arbiter #(.LOADS_OVER_STORES(0), .MAX_WAIT(0)) u1 (
        .clock(clk), .reset(rst_n),
        .load_request_valid(lrv[1]), .load_request_ready(lrr[1]), .load_request_address(lra[1]),
        .load_response_valid(rspv[1]), .load_response_address(rspa[1]), .load_response_value(rspd[1]),
        .store_request_valid(srv[1]), .store_request_ready(srr[1]), .store_request_address(sra[1]),
        .store_request_value(srd[1]), .store_request_byte_en(sbe[1]),
        .memory_read(mrd[1]), .memory_write(mwr[1]), .memory_byte_en(mbe[1]),
        .memory_address_out(mao[1]), .memory_data_out(mdo[1]), .memory_data_in(mdi[1]),
        .memory_address_in(mai[1]), .memory_valid(mv[1]), .memory_ready(mrdy[1]),
        .outstanding_count(oc[1]), .response_error(rerr[1]));

    dmem_multi_port_arbiter #(.LOADS_OVER_STORES(1), .MAX_WAIT(3)) u2 (
        .clock(clk), .reset(rst_n),
        .load_request_valid(lrv[2]), .load_request_ready(lrr[2]), .load_request_address(lra[2]),
        .load_response_valid(rspv[2]), .load_response_address(rspa[2]), .load_response_value(rspd[2]),
        .store_request_valid(srv[2]), .store_request_ready(srr[2]), .store_request_address(sra[2]),
        .store_request_value(srd[2]), .store_request_byte_en(sbe[2]),
        .memory_read(mrd[2]), .memory_write(mwr[2]), .memory_byte_en(mbe[2]),
        .memory_address_out(mao[2]), .memory_data_out(mdo[2]), .memory_data_in(mdi[2]),
        .memory_address_in(mai[2]), .memory_valid(mv[2]), .memory_ready(mrdy[2]),
        .outstanding_count(oc[2]), .response_error(rerr[2]));

    function automatic logic [63:0] port_addr(input int p);
        return 64'h1000 * 64'(p + 1);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pops n expected owners from the scoreboard and returns one response each.
    task automatic drain(input int i, input int n);
        for (int c = 0; c < n; c++) begin
            int p;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL drain_queue: scoreboard empty, required an entry (inst %0d)", i);
                p = 0;
            end else begin
                p = exp_q.pop_front();
            end
            mv[i]  = 1'b1;
            mdi[i] = 64'hD000 + 64'(c);
            mai[i] = port_addr(p);
            @(negedge clk);
            tests++;
            if (rspv[i] !== 2'(1 << p) || rspd[i] !== mdi[i] || rspa[i] !== mai[i]) begin
                fails++;
                $display("FAIL response: inst %0d got valid=%b data=%h addr=%h, required valid=%b data=%h addr=%h",
                         i, rspv[i], rspd[i], rspa[i], 2'(1 << p), mdi[i], mai[i]);
            end
            $display("[TB] inst %0d response -> port %0d data %h", i, p, mdi[i]);
            next_cycle();
        end
        mv[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lrv[i] = 2'b11; srv[i] = 1'b1; mv[i] = 1'b1; mrdy[i] = 1'b1;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (lrr[i] !== 2'b00 || srr[i] !== 1'b0 || mrd[i] !== 1'b0 || mwr[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_grants: inst %0d lrr=%b srr=%b rd=%b wr=%b, required all 0",
                         i, lrr[i], srr[i], mrd[i], mwr[i]);
            end
            tests++;
            if (rspv[i] !== 2'b00 || oc[i] !== 3'd0 || rerr[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: inst %0d rspv=%b count=%0d err=%b, required 0/0/0",
                         i, rspv[i], oc[i], rerr[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            lrv[i] = 2'b00; srv[i] = 1'b0; mv[i] = 1'b0;
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_round_robin();
        lrv[0] = 2'b11;
        for (int c = 0; c < 4; c++) begin
            int p;
            p = c % 2;
            exp_q.push_back(p);
            @(negedge clk);
            tests++;
            if (lrr[0] !== 2'(1 << p) || mrd[0] !== 1'b1 || mwr[0] !== 1'b0 || mao[0] !== port_addr(p)) begin
                fails++;
                $display("FAIL rr_grant%0d: lrr=%b rd=%b wr=%b addr=%h, required lrr=%b rd=1 wr=0 addr=%h",
                         c, lrr[0], mrd[0], mwr[0], mao[0], 2'(1 << p), port_addr(p));
            end
            $display("[TB] inst 0 load grant -> port %0d", p);
            next_cycle();
        end
        @(negedge clk);
        tests++;
        if (lrr[0] !== 2'b00 || mrd[0] !== 1'b0 || oc[0] !== 3'd4) begin
            fails++;
            $display("FAIL rr_full_stall: lrr=%b rd=%b count=%0d, required 00/0/4", lrr[0], mrd[0], oc[0]);
        end
        next_cycle();
        lrv[0] = 2'b00;
        drain(0, 4);
        tests++;
        if (oc[0] !== 3'd0) begin
            fails++;
            $display("FAIL rr_drained: count=%0d, required 0", oc[0]);
        end
    endtask

    task automatic test_full_fifo();
        lrv[0] = 2'b01;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(0);
            @(negedge clk);
            tests++;
            if (lrr[0] !== 2'b01) begin
                fails++;
                $display("FAIL fill_grant%0d: lrr=%b, required 01", c, lrr[0]);
            end
            next_cycle();
        end
        // Response and a new request in the same cycle while full.
        mv[0]  = 1'b1;
        mdi[0] = 64'hF00D;
        mai[0] = port_addr(0);
        void'(exp_q.pop_front());
        @(negedge clk);
        tests++;
        if (lrr[0] !== 2'b00 || mrd[0] !== 1'b0 || rspv[0] !== 2'b01) begin
            fails++;
            $display("FAIL full_pop_cycle: lrr=%b rd=%b rspv=%b, required 00/0/01", lrr[0], mrd[0], rspv[0]);
        end
        next_cycle();
        mv[0] = 1'b0;
        tests++;
        if (oc[0] !== 3'd3) begin
            fails++;
            $display("FAIL full_count_after_pop: count=%0d, required 3", oc[0]);
        end
        exp_q.push_back(0);
        @(negedge clk);
        tests++;
        if (lrr[0] !== 2'b01 || mrd[0] !== 1'b1) begin
            fails++;
            $display("FAIL full_regrant: lrr=%b rd=%b, required 01/1", lrr[0], mrd[0]);
        end
        next_cycle();
        lrv[0] = 2'b00;
        tests++;
        if (oc[0] !== 3'd4) begin
            fails++;
            $display("FAIL full_count_refill: count=%0d, required 4", oc[0]);
        end
        drain(0, 4);
    endtask

    task automatic test_store_aging();
        // memory_ready low: nothing issued, and the age counter must not move.
        lrv[0] = 2'b11; srv[0] = 1'b1; mrdy[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (mrd[0] !== 1'b0 || mwr[0] !== 1'b0 || lrr[0] !== 2'b00 || srr[0] !== 1'b0) begin
            fails++;
            $display("FAIL not_ready: rd=%b wr=%b lrr=%b srr=%b, required all 0", mrd[0], mwr[0], lrr[0], srr[0]);
        end
        next_cycle();
        mrdy[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) begin
                // Loads aged out after 8 lost cycles; rr_ptr now points at port 1.
                tests++;
                if (lrr[0] !== 2'b10 || mrd[0] !== 1'b1 || mwr[0] !== 1'b0 || mao[0] !== port_addr(1)) begin
                    fails++;
                    $display("FAIL aged_load: lrr=%b rd=%b wr=%b addr=%h, required 10/1/0/%h",
                             lrr[0], mrd[0], mwr[0], mao[0], port_addr(1));
                end
                exp_q.push_back(1);
                $display("[TB] inst 0 aged load grant -> port 1");
            end else begin
                tests++;
                if (mwr[0] !== 1'b1 || srr[0] !== 1'b1 || mrd[0] !== 1'b0 || lrr[0] !== 2'b00) begin
                    fails++;
                    $display("FAIL store_pref%0d: wr=%b srr=%b rd=%b lrr=%b, required 1/1/0/00",
                             c, mwr[0], srr[0], mrd[0], lrr[0]);
                end
                if (c == 1) begin
                    tests++;
                    if (mao[0] !== sra[0] || mdo[0] !== srd[0] || mbe[0] !== sbe[0]) begin
                        fails++;
                        $display("FAIL store_payload: addr=%h data=%h be=%h, required %h/%h/%h",
                                 mao[0], mdo[0], mbe[0], sra[0], srd[0], sbe[0]);
                    end
                end
            end
            next_cycle();
        end
        lrv[0] = 2'b00; srv[0] = 1'b0;
        drain(0, 1);
    endtask

    task automatic test_no_aging();
        lrv[1] = 2'b01; srv[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tests++;
            if (mwr[1] !== 1'b1 || mrd[1] !== 1'b0 || lrr[1] !== 2'b00) begin
                fails++;
                $display("FAIL no_aging%0d: wr=%b rd=%b lrr=%b, required 1/0/00", c, mwr[1], mrd[1], lrr[1]);
            end
            next_cycle();
        end
        lrv[1] = 2'b00; srv[1] = 1'b0;
    endtask

    task automatic test_back_to_back_loads_first();
        logic pending;
        pending = 1'b0;
        lrv[2] = 2'b01; srv[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic exp_store;
            int   p;
            exp_store = (c % 4 == 3);
            p = 0;
            mv[2] = pending;
            if (pending) begin
                p = exp_q.pop_front();
                mdi[2] = 64'hB000 + 64'(c);
                mai[2] = port_addr(p);
            end
            @(negedge clk);
            tests++;
            if (mwr[2] !== exp_store || mrd[2] !== !exp_store || srr[2] !== exp_store ||
                lrr[2] !== (exp_store ? 2'b00 : 2'b01)) begin
                fails++;
                $display("FAIL lof_cycle%0d: wr=%b rd=%b srr=%b lrr=%b, required store=%b",
                         c, mwr[2], mrd[2], srr[2], lrr[2], exp_store);
            end
            if (pending) begin
                tests++;
                if (rspv[2] !== 2'(1 << p) || rspd[2] !== mdi[2]) begin
                    fails++;
                    $display("FAIL lof_resp%0d: rspv=%b data=%h, required %b/%h",
                             c, rspv[2], rspd[2], 2'(1 << p), mdi[2]);
                end
            end
            if (!exp_store) exp_q.push_back(0);
            $display("[TB] inst 2 cycle %0d grant %s", c, exp_store ? "store" : "load");
            next_cycle();
            pending = !exp_store;
        end
        lrv[2] = 2'b00; srv[2] = 1'b0; mv[2] = 1'b0;
        if (pending) drain(2, 1);
        tests++;
        if (oc[2] !== 3'd0) begin
            fails++;
            $display("FAIL lof_drained: count=%0d, required 0", oc[2]);
        end
    endtask

    task automatic test_response_error();
        tests++;
        if (oc[0] !== 3'd0 || rerr[0] !== 1'b0) begin
            fails++;
            $display("FAIL err_precond: count=%0d err=%b, required 0/0", oc[0], rerr[0]);
        end
        mv[0] = 1'b1; mdi[0] = 64'hBAD; mai[0] = 64'hBAD;
        @(negedge clk);
        tests++;
        if (rspv[0] !== 2'b00) begin
            fails++;
            $display("FAIL err_dropped: rspv=%b, required 00", rspv[0]);
        end
        next_cycle();
        mv[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (rerr[0] !== 1'b1) begin
                fails++;
                $display("FAIL err_sticky%0d: err=%b, required 1", c, rerr[0]);
            end
            next_cycle();
        end
        // One load in flight, then reset flushes it.
        lrv[0] = 2'b01;
        next_cycle();
        lrv[0] = 2'b00;
        tests++;
        if (oc[0] !== 3'd1) begin
            fails++;
            $display("FAIL err_inflight: count=%0d, required 1", oc[0]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (rerr[0] !== 1'b0 || oc[0] !== 3'd0) begin
            fails++;
            $display("FAIL err_reset_clear: err=%b count=%0d, required 0/0", rerr[0], oc[0]);
        end
        next_cycle();
        rst_n = 1'b1;
        mv[0] = 1'b1;
        @(negedge clk);
        tests++;
        if (rspv[0] !== 2'b00) begin
            fails++;
            $display("FAIL stale_resp_dropped: rspv=%b, required 00", rspv[0]);
        end
        next_cycle();
        mv[0] = 1'b0;
        tests++;
        if (rerr[0] !== 1'b1) begin
            fails++;
            $display("FAIL stale_resp_error: err=%b, required 1", rerr[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            lrv[i] = 2'b00; lra[i] = {port_addr(1), port_addr(0)};
            srv[i] = 1'b0; sra[i] = 64'h3000; srd[i] = 64'hDEAD_BEEF_0000_0001; sbe[i] = 8'hA5;
            mdi[i] = '0; mai[i] = '0; mv[i] = 1'b0; mrdy[i] = 1'b1;
        end
        test_reset();
        test_round_robin();
        test_full_fifo();
        test_store_aging();
        test_no_aging();
        test_back_to_back_loads_first();
        test_response_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
